// File: rtl/bus_cycle_controller.sv
// Bus cycle controller for the microprocessor system board.
// Shares the single external bus between the CPU core (port 0) and the DMA
// engine (port 1). A round-robin arbiter picks a winner in IDLE. The T1-T4
// sequencer then runs the bus cycle, inserting per-device wait states and
// stretching the cycle while the external ready line is low. The five
// active-low chip selects are decoded once, when the winner is granted, and
// are held in a register until the cycle completes.

module bus_cycle_controller #(
    parameter int unsigned EEPROM_WAIT = 2,
    parameter int unsigned SRAM_WAIT   = 0,
    parameter int unsigned IO_WAIT     = 1,
    parameter int unsigned TIMEOUT     = 15
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req0,
    input  logic [15:0] addr0,
    input  logic        mio0,
    input  logic        wr0,
    input  logic [7:0]  wdata0,

    input  logic        req1,
    input  logic [15:0] addr1,
    input  logic        mio1,
    input  logic        wr1,
    input  logic [7:0]  wdata1,

    output logic        ack0,
    output logic        ack1,
    output logic        err,
    output logic [7:0]  rdata,

    output logic [15:0] address,
    output logic        MIO,
    output logic        ALE,
    output logic        rd_n,
    output logic        wr_n,
    output logic [7:0]  dout,
    input  logic [7:0]  din,
    input  logic        ready,
    output logic [4:0]  cs,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        TW   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5
    } state_t;

    // Chip-select patterns (active low): bit0 PPI1, bit1 PPI2, bit2 PIT,
    // bit3 EEPROM, bit4 SRAM.
    localparam logic [4:0] CS_NONE   = 5'b11111;
    localparam logic [4:0] CS_PPI1   = 5'b11110;
    localparam logic [4:0] CS_PPI2   = 5'b11101;
    localparam logic [4:0] CS_PIT    = 5'b11011;
    localparam logic [4:0] CS_EEPROM = 5'b10111;
    localparam logic [4:0] CS_SRAM   = 5'b01111;

    localparam logic [3:0] WAIT_EEPROM  = 4'(EEPROM_WAIT);
    localparam logic [3:0] WAIT_SRAM    = 4'(SRAM_WAIT);
    localparam logic [3:0] WAIT_IO      = 4'(IO_WAIT);
    localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);

    // Address decode. I/O space only looks at a[3] and a[0]; memory space
    // only looks at a[11:10]. Anything else selects no device.
    function automatic logic [4:0] decode_cs(input logic is_mem,
                                             input logic [15:0] a);
        logic [4:0] sel;
        sel = CS_NONE;
        if (is_mem) begin
            case (a[11:10])
                2'b01:   sel = CS_EEPROM;
                2'b10:   sel = CS_SRAM;
                default: sel = CS_NONE;
            endcase
        end else begin
            case ({a[3], a[0]})
                2'b00:   sel = CS_PPI1;
                2'b01:   sel = CS_PPI2;
                2'b10:   sel = CS_PIT;
                default: sel = CS_NONE;
            endcase
        end
        return sel;
    endfunction

    // Wait states for the decoded device. Every I/O cycle, mapped or not,
    // gets the I/O wait count; unmapped memory runs without waits.
    function automatic logic [3:0] device_wait(input logic is_mem,
                                               input logic [4:0] sel);
        logic [3:0] w;
        w = 4'd0;
        if (!is_mem) begin
            w = WAIT_IO;
        end else if (sel == CS_EEPROM) begin
            w = WAIT_EEPROM;
        end else if (sel == CS_SRAM) begin
            w = WAIT_SRAM;
        end
        return w;
    endfunction

    state_t      state;
    state_t      state_next;

    logic        last_served;
    logic        grant_valid;
    logic        grant_port;
    logic        abort_next;

    logic [15:0] sel_addr;
    logic        sel_mio;
    logic        sel_wr;
    logic [7:0]  sel_wdata;

    logic        txn_port;
    logic        txn_wr;
    logic [7:0]  txn_wdata;

    logic [3:0]  wait_cnt;
    logic [3:0]  timeout_cnt;

    // The request fields of whichever port the arbiter is granting.
    assign sel_addr  = grant_port ? addr1  : addr0;
    assign sel_mio   = grant_port ? mio1   : mio0;
    assign sel_wr    = grant_port ? wr1    : wr0;
    assign sel_wdata = grant_port ? wdata1 : wdata0;

    assign busy = (state != IDLE);

    // State register for the bus cycle sequencer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the arbitration decision. Port 1 wins only when
    // it is the sole requester or port 0 was the one served last time.
    // From TW the cycle aborts once ready has been low for the full timeout
    // with the device wait count already exhausted.
    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_port  = 1'b0;
        abort_next  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_valid = 1'b1;
                    grant_port  = req1 && (!req0 || !last_served);
                    state_next  = T1;
                end
            end
            T1: begin
                state_next = T2;
            end
            T2: begin
                if ((wait_cnt == 4'd0) && ready) begin
                    state_next = T3;
                end else begin
                    state_next = TW;
                end
            end
            TW: begin
                if (wait_cnt == 4'd0) begin
                    if (ready) begin
                        state_next = T3;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        state_next = T4;
                        abort_next = 1'b1;
                    end
                end
            end
            T3: begin
                state_next = T4;
            end
            T4: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the winning requester's direction and write data on the grant
    // so that later changes on its inputs cannot disturb the running cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            txn_port  <= 1'b0;
            txn_wr    <= 1'b0;
            txn_wdata <= 8'h00;
        end else if (grant_valid) begin
            txn_port  <= grant_port;
            txn_wr    <= sel_wr;
            txn_wdata <= sel_wdata;
        end
    end

    // Wait-state and ready-timeout counters. T1 loads the device wait count
    // from the already-registered cs/MIO. T2 and TW count it down. The
    // timeout counter only advances in TW once the device waits are spent
    // and ready is still low.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt    <= 4'd0;
            timeout_cnt <= 4'd0;
        end else begin
            case (state)
                T1: begin
                    wait_cnt    <= device_wait(MIO, cs);
                    timeout_cnt <= 4'd0;
                end
                T2: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                TW: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else if (!ready) begin
                        timeout_cnt <= timeout_cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // External bus drive. Address, MIO and chip select go out with ALE on
    // entry to T1. The strobe and write data start on entry to T2. Strobes,
    // cs and dout are released on entry to T4. Address and MIO keep their
    // last value while the bus is idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            address <= 16'h0000;
            MIO     <= 1'b0;
            ALE     <= 1'b0;
            cs      <= CS_NONE;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            dout    <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        ALE     <= 1'b1;
                        address <= sel_addr;
                        MIO     <= sel_mio;
                        cs      <= decode_cs(sel_mio, sel_addr);
                    end
                end
                T1: begin
                    ALE <= 1'b0;
                    if (txn_wr) begin
                        wr_n <= 1'b0;
                        dout <= txn_wdata;
                    end else begin
                        rd_n <= 1'b0;
                    end
                end
                default: begin
                    if (state_next == T4) begin
                        rd_n <= 1'b1;
                        wr_n <= 1'b1;
                        cs   <= CS_NONE;
                        dout <= 8'h00;
                    end
                end
            endcase
        end
    end

    // Read data capture at the end of T3. Unmapped reads float the bus, so
    // they return all ones instead of whatever din happens to show.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= 8'h00;
        end else if ((state == T3) && !txn_wr) begin
            rdata <= (cs != CS_NONE) ? din : 8'hFF;
        end
    end

    // Completion pulses for the served port. err accompanies the ack only
    // when the cycle was aborted by the ready timeout. The served port is
    // recorded here for the round-robin decision.
    always_ff @(posedge clock) begin
        if (reset) begin
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err         <= 1'b0;
            last_served <= 1'b1;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err  <= 1'b0;
            if (state_next == T4) begin
                ack0        <= !txn_port;
                ack1        <= txn_port;
                err         <= abort_next;
                last_served <= txn_port;
            end
        end
    end

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Self-checking bench for bus_cycle_controller. Each transaction is predicted
// from the bus rules: decoded cs, wait states, ready stretching, timeout
// abort and round-robin order. The prediction is compared with what the bus
// pins do cycle by cycle.

module tb_bus_cycle_controller;

    localparam int TIMEOUT = 15;
    localparam int LIMIT   = 60;

    logic        clock;
    logic        reset;
    logic        req0, req1;
    logic [15:0] addr0, addr1;
    logic        mio0, mio1;
    logic        wr0, wr1;
    logic [7:0]  wdata0, wdata1;
    logic        ack0, ack1, err;
    logic [7:0]  rdata;
    logic [15:0] address;
    logic        MIO, ALE, rd_n, wr_n;
    logic [7:0]  dout;
    logic [7:0]  din;
    logic        ready;
    logic [4:0]  cs;
    logic        busy;

    bus_cycle_controller dut (
        .clock   (clock),
        .reset   (reset),
        .req0    (req0),
        .addr0   (addr0),
        .mio0    (mio0),
        .wr0     (wr0),
        .wdata0  (wdata0),
        .req1    (req1),
        .addr1   (addr1),
        .mio1    (mio1),
        .wr1     (wr1),
        .wdata1  (wdata1),
        .ack0    (ack0),
        .ack1    (ack1),
        .err     (err),
        .rdata   (rdata),
        .address (address),
        .MIO     (MIO),
        .ALE     (ALE),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .dout    (dout),
        .din     (din),
        .ready   (ready),
        .cs      (cs),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          tests = 0;
    int          fails = 0;

    logic [15:0] pAddr  [2];
    logic        pMio   [2];
    logic        pWr    [2];
    logic [7:0]  pWdata [2];
    bit          pending[2];
    int          lastServed;
    logic [7:0]  expRdata;

    // Chip select that the memory map assigns to an address.
    function automatic logic [4:0] specCs(input logic m, input logic [15:0] a);
        if (!m) begin
            if (!a[3]) return a[0] ? 5'b11101 : 5'b11110;
            if (!a[0]) return 5'b11011;
            return 5'b11111;
        end
        if (a[11:10] == 2'b01) return 5'b10111;
        if (a[11:10] == 2'b10) return 5'b01111;
        return 5'b11111;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drivePort(input int p);
        if (p == 0) begin
            req0 = pending[0]; addr0 = pAddr[0]; mio0 = pMio[0];
            wr0 = pWr[0]; wdata0 = pWdata[0];
        end else begin
            req1 = pending[1]; addr1 = pAddr[1]; mio1 = pMio[1];
            wr1 = pWr[1]; wdata1 = pWdata[1];
        end
    endtask

    task automatic scramblePort(input int p);
        if (p == 0) begin
            addr0 = 16'($urandom); mio0 = 1'($urandom);
            wr0 = 1'($urandom); wdata0 = 8'($urandom);
        end else begin
            addr1 = 16'($urandom); mio1 = 1'($urandom);
            wr1 = 1'($urandom); wdata1 = 8'($urandom);
        end
    endtask

    task automatic applyStimulus(input int p, input logic [15:0] a, input logic m,
                                 input logic w, input logic [7:0] d);
        pAddr[p] = a; pMio[p] = m; pWr[p] = w; pWdata[p] = d;
        pending[p] = 1'b1;
        drivePort(p);
    endtask

    // Runs one transaction starting in an IDLE cycle (called just after a
    // negedge) and returns in the following IDLE cycle. readyLow is the
    // number of ready samples held low starting at T2.
    task automatic runTxn(input int readyLow, input logic [7:0] dinVal, input bit keep);
        int win, dw, tBase, tw, lowExp, ackExp;
        bit abort, done;
        logic [4:0] eCs, csT1;
        logic [15:0] addrT1, addrT4;
        logic mioT1, busy0, errV;
        logic [1:0] ackVec;
        logic [7:0] rdV;
        int aleCnt, lowCnt, csBad, doutBad, kindBad, ackAt;

        if (pending[0] && pending[1]) win = (lastServed == 1) ? 0 : 1;
        else win = pending[1] ? 1 : 0;

        eCs = specCs(pMio[win], pAddr[win]);
        if (!pMio[win]) dw = 1;
        else if (eCs == 5'b10111) dw = 2;
        else dw = 0;
        tBase = (dw > 1) ? dw : 1;
        if (readyLow - tBase >= TIMEOUT) begin
            abort = 1'b1; tw = tBase + TIMEOUT - 1;
            lowExp = tw + 1; ackExp = 3 + tw;
        end else begin
            abort = 1'b0; tw = (dw > readyLow) ? dw : readyLow;
            lowExp = 2 + tw; ackExp = 4 + tw;
        end
        if (!pWr[win] && !abort) expRdata = (eCs != 5'b11111) ? dinVal : 8'hFF;

        aleCnt = 0; lowCnt = 0; csBad = 0; doutBad = 0; kindBad = 0; ackAt = -1;
        done = 1'b0; csT1 = 5'h0; addrT1 = 16'h0; addrT4 = 16'h0; mioT1 = 1'b0;
        busy0 = 1'b1; errV = 1'b0; ackVec = 2'b00; rdV = 8'h00;
        for (int c = 0; c < LIMIT && !done; c++) begin
            if (c > 0) @(negedge clock);
            ready = !(c >= 2 && (c - 2) < readyLow);
            din = dinVal;
            if (c == 0) busy0 = busy;
            if (c == 1) begin
                csT1 = cs; addrT1 = address; mioT1 = MIO;
                scramblePort(win);
            end
            if (ALE === 1'b1) aleCnt++;
            if (rd_n === 1'b0 || wr_n === 1'b0) begin
                lowCnt++;
                if (cs !== eCs) csBad++;
                if (dout !== (pWr[win] ? pWdata[win] : 8'h00)) doutBad++;
                if ({rd_n, wr_n} !== (pWr[win] ? 2'b10 : 2'b01)) kindBad++;
            end
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                ackAt = c; ackVec = {ack1, ack0}; errV = err;
                rdV = rdata; addrT4 = address; done = 1'b1;
            end
        end
        if (!keep) pending[win] = 1'b0;
        drivePort(win);
        lastServed = win;

        checkOutput("idle_busy", 32'(busy0), 32'(1'b0));
        checkOutput("t1_cs", 32'(csT1), 32'(eCs));
        checkOutput("t1_address", 32'(addrT1), 32'(pAddr[win]));
        checkOutput("t1_mio", 32'(mioT1), 32'(pMio[win]));
        checkOutput("ale_cycles", 32'(aleCnt), 32'(1));
        checkOutput("strobe_cycles", 32'(lowCnt), 32'(lowExp));
        checkOutput("strobe_cs_bad", 32'(csBad), 32'(0));
        checkOutput("strobe_dout_bad", 32'(doutBad), 32'(0));
        checkOutput("strobe_kind_bad", 32'(kindBad), 32'(0));
        checkOutput("ack_cycle", 32'(ackAt), 32'(ackExp));
        checkOutput("ack_port", 32'(ackVec), 32'(win == 1 ? 2'b10 : 2'b01));
        checkOutput("err", 32'(errV), 32'(abort));
        checkOutput("rdata", 32'(rdV), 32'(expRdata));
        checkOutput("t4_address_hold", 32'(addrT4), 32'(pAddr[win]));

        @(negedge clock);
        ready = 1'b1;
    endtask

    // Directed scenarios first, then randomized traffic from both ports.
    initial begin
        int r, rl;
        reset = 1'b1; ready = 1'b1; din = 8'h00;
        pending[0] = 1'b0; pending[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            pAddr[p] = 16'h0; pMio[p] = 1'b0; pWr[p] = 1'b0; pWdata[p] = 8'h0;
            drivePort(p);
        end
        lastServed = 1; expRdata = 8'h00;

        repeat (3) @(negedge clock);
        checkOutput("reset_bus", 32'({address, MIO, dout, ALE, rd_n, wr_n}),
                    32'({16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1}));
        checkOutput("reset_ctl", 32'({rdata, cs, ack0, ack1, err, busy}),
                    32'({8'h00, 5'b11111, 4'b0000}));
        reset = 1'b0;

        // SRAM read from the CPU.
        applyStimulus(0, 16'h0800, 1'b1, 1'b0, 8'h00);
        runTxn(0, 8'h5A, 1'b0);

        // EEPROM write from the DMA engine.
        applyStimulus(1, 16'h0400, 1'b1, 1'b1, 8'hC3);
        runTxn(0, 8'h00, 1'b0);

        // Both ports requesting continuously; service must alternate.
        applyStimulus(0, 16'h0810, 1'b1, 1'b0, 8'h00);
        applyStimulus(1, 16'h0A20, 1'b1, 1'b1, 8'h11);
        runTxn(0, 8'h21, 1'b1);
        runTxn(0, 8'h22, 1'b1);
        runTxn(0, 8'h23, 1'b1);
        runTxn(0, 8'h24, 1'b0);
        runTxn(0, 8'h25, 1'b0);

        // PIT write stretched by ready low for three samples.
        applyStimulus(0, 16'h0008, 1'b0, 1'b1, 8'h77);
        runTxn(3, 8'h00, 1'b0);

        // PIT read with ready stuck low: timeout abort.
        applyStimulus(1, 16'h0008, 1'b0, 1'b0, 8'h00);
        runTxn(40, 8'hAB, 1'b0);

        // Unmapped I/O read.
        applyStimulus(0, 16'h0009, 1'b0, 1'b0, 8'h00);
        runTxn(0, 8'h3C, 1'b0);

        // Reset while an EEPROM read sits in its wait states.
        applyStimulus(0, 16'h0400, 1'b1, 1'b0, 8'h00);
        ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("mid_reset_bus", 32'({rd_n, wr_n, cs, busy, ALE}),
                    32'({1'b1, 1'b1, 5'b11111, 1'b0, 1'b0}));
        checkOutput("mid_reset_ack", 32'({ack0, ack1, err, rdata}), 32'(0));
        reset = 1'b0; ready = 1'b1;
        lastServed = 1; expRdata = 8'h00;
        runTxn(0, 8'h99, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            if (!pending[0] && !pending[1]) begin
                r = $urandom_range(1, 3);
                for (int p = 0; p < 2; p++)
                    if (r[p]) applyStimulus(p, 16'($urandom), 1'($urandom),
                                            1'($urandom), 8'($urandom));
            end else begin
                for (int p = 0; p < 2; p++)
                    if (!pending[p] && $urandom_range(0, 1) == 1)
                        applyStimulus(p, 16'($urandom), 1'($urandom),
                                      1'($urandom), 8'($urandom));
            end
            r = $urandom_range(0, 9);
            if (r < 6) rl = 0;
            else if (r < 9) rl = $urandom_range(1, 4);
            else rl = 20;
            runTxn(rl, 8'($urandom), 1'b0);
        end
        if (pending[0] || pending[1]) runTxn(0, 8'($urandom), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_cycle_controller.md
# bus_cycle_controller

Sequences every bus transaction of the microprocessor system board and shares the single external bus between two requesters: the CPU core (port 0) and the DMA engine (port 1). It arbitrates round-robin, runs a T1–T4 bus cycle with per-device wait states, and drives the address, MIO, ALE and read/write strobes. It decodes and registers the five active-low chip selects: PPI1, PPI2, PIT, EEPROM and SRAM.

## Interface
- EEPROM_WAIT, 2, wait states inserted for EEPROM cycles
- SRAM_WAIT, 0, wait states for SRAM cycles
- IO_WAIT, 1, wait states for any I/O cycle, including unmapped I/O
- TIMEOUT, 15, maximum consecutive TW cycles with ready low before abort (4-bit counter)

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- req0 / req1  in  1  requester holds high until its ack
- addr0 / addr1  in  16  transaction address
- mio0 / mio1  in  1  1 = memory, 0 = I/O
- wr0 / wr1  in  1  1 = write, 0 = read
- wdata0 / wdata1  in  8  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with ack on timeout abort
- rdata  out  8  read data, held until the next read completes
- address  out  16  bus address
- MIO  out  1  bus memory/IO qualifier
- ALE  out  1  address latch enable
- rd_n, wr_n  out  1  active-low strobes
- dout  out  8  bus write data
- din  in  8  bus read data
- ready  in  1  external ready; low extends cycle
- cs  out  5  chip selects, active low: bit0 PPI1, bit1 PPI2, bit2 PIT, bit3 EEPROM, bit4 SRAM
- busy  out  1  high in any state other than IDLE

## Operation
- Reset values:
  - address, MIO, dout and rdata are 0.
  - ALE, ack0, ack1, err and busy are 0.
  - rd_n and wr_n are 1; cs is 5'b11111.
  - State is IDLE; the round-robin pointer is set to "last served = 1".
- Decode for I/O (MIO = 0):
  - a[3]=0, a[0]=0 → 11110 (PPI1)
  - a[3]=0, a[0]=1 → 11101 (PPI2)
  - a[3]=1, a[0]=0 → 11011 (PIT)
  - else → 11111
- Decode for memory (MIO = 1):
  - a[11:10]=01 → 10111 (EEPROM)
  - a[11:10]=10 → 01111 (SRAM)
  - else → 11111
- Unmapped cycles still run full sequence, no cs asserted, wait count 0 for memory and IO_WAIT for I/O, reads return 8'hFF.
- Arbitration occurs in IDLE only:
  - A single request wins.
  - With both requesting, the requester not served last wins.
  - The winner's addr, mio, wr and wdata are latched on the IDLE→T1 edge; later input changes are ignored until the ack.
- State sequence:
  - IDLE → T1 when any req is high.
  - T1: ALE=1, address, MIO and cs are driven; the wait counter loads the device wait count. → T2.
  - T2: ALE=0; rd_n=0 for a read, or wr_n=0 with dout = wdata for a write. → T3 if wait count = 0 and ready = 1, else → TW.
  - TW: the counter decrements while non-zero. → T3 when counter = 0 and ready = 1. If ready stays low for TIMEOUT consecutive TW cycles with counter = 0, go to T4 with abort.
  - T3: for reads, rdata ← din (8'hFF if unmapped); strobe remains asserted. → T4.
  - T4:
    - Strobes deassert and cs returns to 11111.
    - dout returns to 0; address and MIO hold their values.
    - The winner's ack pulses; err also pulses on abort, and on abort rdata is unchanged.
    - The served requester is recorded. → IDLE.
- A req still high in the IDLE after its ack is a new transaction.
- Reset in any state: the next edge restores reset values, no ack is issued, and the pending transaction is dropped.

## Timing
- Request sampled in IDLE at edge 0: T1 at edge 1, T2 at edge 2, T3 at edge 2+1+W, ack high in the cycle after edge 3+W. W = device waits plus extra ready-low cycles.
- Minimum transaction is 5 clocks including IDLE; back-to-back throughput is 1 transaction per 5+W clocks.
- ALE is high for exactly 1 cycle (T1).
- The strobe is low for 2+W cycles (T2, TWs, T3).
- ready is sampled only in T2 and TW.

## Test plan
- SRAM read: after reset, req0 with addr0=16'h0800, mio0=1, wr0=0, din=8'h5A.
  - Required: cs=01111 in T1–T3; rd_n low 2 cycles; ack0 in the 5th cycle; rdata=8'h5A.
- EEPROM write: req1 with addr1=16'h0400, wdata1=8'hC3.
  - Required: cs=10111; wr_n low 4 cycles; dout=8'hC3 during strobe; ack1 7 cycles after request; no ack0.
- Contention: req0 and req1 held high continuously.
  - Required: acks alternate ack0, ack1, ack0, ack1, each 5 clocks apart for SRAM addresses.
- PIT write with ready: addr 16'h0008, mio=0; ready low for 3 cycles from T2.
  - Required: cs=11011; 3 TW cycles; no err.
  - With ready held low for 15 TW cycles: T4 follows, ack and err pulse together, rdata unchanged.
- Unmapped I/O read: addr 16'h0009, mio=0.
  - Required: cs stays 11111; 1 TW cycle; rdata=8'hFF; normal ack.
- Reset during TW of an EEPROM read.
  - Required: next cycle rd_n=1, cs=11111, busy=0, no ack; a following req0 completes normally.
